// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RISC-V funct3 size codes
// and the access legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    READ_WAIT,
    RESP
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Illegal size codes, unsigned stores and misaligned halfword/word accesses all fault.
  function automatic logic accessFault(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] byteOff);
    logic fault;
    fault = 1'b0;
    case (funct3)
      LB:      fault = 1'b0;
      LH:      fault = byteOff[0];
      LW:      fault = (byteOff != 2'b00);
      LBU:     fault = we;
      LHU:     fault = we | byteOff[0];
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load lane selection: picks the addressed byte/halfword out of the
// RAM word and sign- or zero-extends it according to funct3.
module load_formatter
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byteOff,
  input  logic [31:0] rawData,
  output logic [31:0] loadData
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    laneByte = rawData[8*byteOff +: 8];
    laneHalf = rawData[16*byteOff[1] +: 16];
    loadData = rawData;
    case (funct3)
      LB:      loadData = {{24{laneByte[7]}}, laneByte};
      LH:      loadData = {{16{laneHalf[15]}}, laneHalf};
      LBU:     loadData = {24'h000000, laneByte};
      LHU:     loadData = {16'h0000, laneHalf};
      default: loadData = rawData;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the execute stage and a synchronous
// data RAM with one cycle of read latency.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int Address_Width_RAM = 12,
  parameter int Data_Width        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [2:0]                   req_funct3,
  input  logic [Address_Width_RAM-1:0] req_addr,
  input  logic [Data_Width-1:0]        req_wdata,
  output logic                         resp_valid,
  output logic [Data_Width-1:0]        resp_rdata,
  output logic                         resp_fault,
  output logic [Address_Width_RAM-1:0] mem_addr,
  output logic                         mem_we,
  output logic [3:0]                   mem_be,
  output logic [Data_Width-1:0]        mem_wdata,
  input  logic [Data_Width-1:0]        mem_rdata
);

  lsu_state_e                   state_q, state_d;
  logic                         we_q, we_d;
  logic [2:0]                   funct3_q, funct3_d;
  logic [Address_Width_RAM-1:0] addr_q, addr_d;
  logic [Data_Width-1:0]        wdata_q, wdata_d;
  logic                         fault_q, fault_d;
  logic [Data_Width-1:0]        rdata_q, rdata_d;

  logic                         reqFault;
  logic [Data_Width-1:0]        loadData;

  assign reqFault = accessFault(req_we, req_funct3, req_addr[1:0]);

  load_formatter u_formatter (
    .funct3  (funct3_q),
    .byteOff (addr_q[1:0]),
    .rawData (mem_rdata),
    .loadData(loadData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state and output logic; RAM signals are only non-zero during ACCESS.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fault_d    = fault_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          fault_d  = reqFault;
          if (reqFault) begin
            rdata_d = '0;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end

      ACCESS: begin
        mem_addr = {addr_q[Address_Width_RAM-1:2], 2'b00};
        case (funct3_q[1:0])
          2'b00:   mem_be = 4'b0001 << addr_q[1:0];
          2'b01:   mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
          default: mem_be = 4'b1111;
        endcase
        if (we_q) begin
          mem_we = 1'b1;
          case (funct3_q[1:0])
            2'b00:   mem_wdata = {4{wdata_q[7:0]}};
            2'b01:   mem_wdata = {2{wdata_q[15:0]}};
            default: mem_wdata = wdata_q;
          endcase
          state_d = RESP;
        end else begin
          state_d = READ_WAIT;
        end
      end

      READ_WAIT: begin
        rdata_d = loadData;
        state_d = RESP;
      end

      RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // Observations gathered by applyStimulus for one request
  int          respCycle;
  int          accCycles;
  int          weCycles;
  int          busyReady;
  logic        obsFault;
  logic [31:0] obsRdata;
  logic [3:0]  obsBe;
  logic [11:0] obsAddr;
  logic [31:0] obsWdata;
  logic        postValid;
  logic        postReady;

  load_store_unit #(.Address_Width_RAM(12), .Data_Width(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and records RAM activity and the response, counting
  // cycles from the accept edge (cycle 1 is the one right after it).
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [11:0] addr, input logic [31:0] wdata,
                               input logic [31:0] ramWord);
    respCycle = 0; accCycles = 0; weCycles = 0; busyReady = 0;
    obsFault = 1'b0; obsRdata = '0; obsBe = '0; obsAddr = '0; obsWdata = '0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_rdata  = ramWord;
    @(posedge clk);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req_valid = 1'b0;
      if (req_ready) busyReady++;
      if (mem_we) weCycles++;
      if (mem_be != 4'b0000 || mem_we) begin
        accCycles++;
        obsBe    = mem_be;
        obsAddr  = mem_addr;
        obsWdata = mem_wdata;
      end
      if (resp_valid) begin
        respCycle = cyc;
        obsFault  = resp_fault;
        obsRdata  = resp_rdata;
        break;
      end
    end
    @(negedge clk);
    postValid = resp_valid;
    postReady = req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_fault !== 1'b0 ||
        mem_we !== 1'b0 || mem_be !== 4'b0000 || resp_rdata !== 32'h0 ||
        mem_addr !== 12'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b fault=%b we=%b be=%b rdata=%h addr=%h wdata=%h, required ready=1 others 0",
               req_ready, resp_valid, resp_fault, mem_we, mem_be, resp_rdata, mem_addr, mem_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    applyStimulus(1'b1, 3'b010, 12'h104, 32'hDEADBEEF, 32'h0);
    checks++;
    if (obsAddr !== 12'h104 || obsBe !== 4'b1111 || obsWdata !== 32'hDEADBEEF || weCycles !== 1) begin
      errors++;
      $display("[TB] FAIL sw_access: addr=%h be=%b wdata=%h weCycles=%0d, required 104 1111 deadbeef 1",
               obsAddr, obsBe, obsWdata, weCycles);
    end
    checks++;
    if (respCycle !== 2 || obsFault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sw_resp: cycle=%0d fault=%b, required cycle 2 fault 0", respCycle, obsFault);
    end
    checks++;
    if (postValid !== 1'b0 || postReady !== 1'b1 || busyReady !== 0) begin
      errors++;
      $display("[TB] FAIL sw_handshake: postValid=%b postReady=%b busyReady=%0d, required 0 1 0",
               postValid, postReady, busyReady);
    end
  endtask

  task automatic test_store_byte_half();
    applyStimulus(1'b1, 3'b000, 12'h013, 32'h000000A5, 32'h0);
    checks++;
    if (obsAddr !== 12'h010 || obsBe !== 4'b1000 || obsWdata !== 32'hA5A5A5A5 || respCycle !== 2) begin
      errors++;
      $display("[TB] FAIL sb_access: addr=%h be=%b wdata=%h cycle=%0d, required 010 1000 a5a5a5a5 2",
               obsAddr, obsBe, obsWdata, respCycle);
    end
    applyStimulus(1'b1, 3'b001, 12'h020, 32'h1234BEEF, 32'h0);
    checks++;
    if (obsAddr !== 12'h020 || obsBe !== 4'b0011 || obsWdata !== 32'hBEEFBEEF) begin
      errors++;
      $display("[TB] FAIL sh_low: addr=%h be=%b wdata=%h, required 020 0011 beefbeef", obsAddr, obsBe, obsWdata);
    end
  endtask

  task automatic test_loads();
    applyStimulus(1'b0, 3'b000, 12'h102, 32'h0, 32'h1280FF34);
    checks++;
    if (obsRdata !== 32'hFFFFFF80 || respCycle !== 3 || obsFault !== 1'b0 || weCycles !== 0) begin
      errors++;
      $display("[TB] FAIL lb: rdata=%h cycle=%0d fault=%b weCycles=%0d, required ffffff80 3 0 0",
               obsRdata, respCycle, obsFault, weCycles);
    end
    checks++;
    if (obsAddr !== 12'h100) begin
      errors++;
      $display("[TB] FAIL lb_addr: addr=%h, required 100", obsAddr);
    end
    applyStimulus(1'b0, 3'b100, 12'h102, 32'h0, 32'h1280FF34);
    checks++;
    if (obsRdata !== 32'h00000080 || respCycle !== 3) begin
      errors++;
      $display("[TB] FAIL lbu: rdata=%h cycle=%0d, required 00000080 3", obsRdata, respCycle);
    end
    applyStimulus(1'b0, 3'b001, 12'h102, 32'h0, 32'h80010000);
    checks++;
    if (obsRdata !== 32'hFFFF8001) begin
      errors++;
      $display("[TB] FAIL lh: rdata=%h, required ffff8001", obsRdata);
    end
    applyStimulus(1'b0, 3'b101, 12'h102, 32'h0, 32'h80010000);
    checks++;
    if (obsRdata !== 32'h00008001) begin
      errors++;
      $display("[TB] FAIL lhu: rdata=%h, required 00008001", obsRdata);
    end
    applyStimulus(1'b0, 3'b000, 12'h101, 32'h0, 32'h1280FF34);
    checks++;
    if (obsRdata !== 32'hFFFFFFFF) begin
      errors++;
      $display("[TB] FAIL lb_lane1: rdata=%h, required ffffffff", obsRdata);
    end
  endtask

  task automatic test_rdata_hold();
    applyStimulus(1'b0, 3'b010, 12'h200, 32'h0, 32'h12345678);
    checks++;
    if (obsRdata !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL lw: rdata=%h, required 12345678", obsRdata);
    end
    applyStimulus(1'b1, 3'b001, 12'h102, 32'h0000BEEF, 32'hCAFEF00D);
    checks++;
    if (obsRdata !== 32'h12345678 || obsBe !== 4'b1100 || obsWdata !== 32'hBEEFBEEF) begin
      errors++;
      $display("[TB] FAIL store_hold: rdata=%h be=%b wdata=%h, required 12345678 1100 beefbeef",
               obsRdata, obsBe, obsWdata);
    end
  endtask

  task automatic test_faults();
    applyStimulus(1'b0, 3'b010, 12'h101, 32'h0, 32'hFFFFFFFF);
    checks++;
    if (obsFault !== 1'b1 || respCycle !== 1 || accCycles !== 0 || obsRdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL lw_misaligned: fault=%b cycle=%0d accCycles=%0d rdata=%h, required 1 1 0 0",
               obsFault, respCycle, accCycles, obsRdata);
    end
    applyStimulus(1'b1, 3'b100, 12'h040, 32'h11223344, 32'h0);
    checks++;
    if (obsFault !== 1'b1 || weCycles !== 0 || accCycles !== 0 || respCycle !== 1) begin
      errors++;
      $display("[TB] FAIL store_f3_100: fault=%b weCycles=%0d accCycles=%0d cycle=%0d, required 1 0 0 1",
               obsFault, weCycles, accCycles, respCycle);
    end
    applyStimulus(1'b0, 3'b010, 12'h000, 32'h0, 32'hA5A5A5A5);
    applyStimulus(1'b0, 3'b011, 12'h000, 32'h0, 32'hA5A5A5A5);
    checks++;
    if (obsFault !== 1'b1 || obsRdata !== 32'h0 || accCycles !== 0) begin
      errors++;
      $display("[TB] FAIL load_f3_011: fault=%b rdata=%h accCycles=%0d, required 1 0 0",
               obsFault, obsRdata, accCycles);
    end
    applyStimulus(1'b0, 3'b001, 12'h103, 32'h0, 32'h0);
    checks++;
    if (obsFault !== 1'b1 || accCycles !== 0) begin
      errors++;
      $display("[TB] FAIL lh_misaligned: fault=%b accCycles=%0d, required 1 0", obsFault, accCycles);
    end
  endtask

  task automatic test_reset_midop();
    int sawValid;
    applyStimulus(1'b0, 3'b010, 12'h300, 32'h0, 32'h0BADF00D);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 12'h304;
    mem_rdata  = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_fault !== 1'b0 ||
        mem_we !== 1'b0 || mem_be !== 4'b0000 || resp_rdata !== 32'h0 ||
        mem_addr !== 12'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_midop: ready=%b valid=%b fault=%b we=%b be=%b rdata=%h addr=%h wdata=%h, required ready=1 others 0",
               req_ready, resp_valid, resp_fault, mem_we, mem_be, resp_rdata, mem_addr, mem_wdata);
    end
    sawValid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) sawValid++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) sawValid++;
    end
    checks++;
    if (sawValid !== 0) begin
      errors++;
      $display("[TB] FAIL reset_no_resp: resp_valid cycles=%0d, required 0", sawValid);
    end
    applyStimulus(1'b0, 3'b100, 12'h003, 32'h0, 32'h7F000000);
    checks++;
    if (obsRdata !== 32'h0000007F || respCycle !== 3 || obsFault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset_load: rdata=%h cycle=%0d fault=%b, required 0000007f 3 0",
               obsRdata, respCycle, obsFault);
    end
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    mem_rdata  = '0;
    test_reset();
    test_store_word();
    test_store_byte_half();
    test_loads();
    test_rdata_hold();
    test_faults();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter Address_Width_RAM, default 12, byte-address width of data RAM.
REQ-002 Parameter Data_Width, default 32, data word width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req_valid  input  1  access request from execute stage.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V size/sign code.
REQ-009 req_addr  input  Address_Width_RAM  byte address (ALU result).
REQ-010 req_wdata  input  Data_Width  store data (rs2 value).
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  Data_Width  formatted load result.
REQ-013 resp_fault  output  1  valid with resp_valid; misaligned or illegal access.
REQ-014 mem_addr  output  Address_Width_RAM  word-aligned RAM address.
REQ-015 mem_we  output  1  RAM write enable.
REQ-016 mem_be  output  4  RAM byte enables.
REQ-017 mem_wdata  output  Data_Width  lane-positioned store data.
REQ-018 mem_rdata  input  Data_Width  RAM read data, valid one cycle after address.

Function
REQ-019 FSM states IDLE, ACCESS, READ_WAIT, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE: on req_valid, capture we/funct3/addr/wdata; go to RESP if faulted, else ACCESS.
REQ-021 Fault: funct3 not in {000,001,010,100,101}; store with funct3 100/101; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-022 Faulted request: no RAM access; RESP with resp_fault=1, resp_rdata=0.
REQ-023 ACCESS: mem_addr={addr[AW-1:2],2'b00}, drive mem_be; store asserts mem_we and goes to RESP; load goes to READ_WAIT.
REQ-024 mem_we, mem_be, mem_wdata, mem_addr are 0 in all states except ACCESS.
REQ-025 Store byte: mem_be=1<<addr[1:0], mem_wdata = byte replicated x4.
REQ-026 Store half: mem_be=0011 (addr[1]=0) or 1100, mem_wdata = halfword replicated x2.
REQ-027 Store word: mem_be=1111, mem_wdata=req_wdata.
REQ-028 READ_WAIT: select byte mem_rdata[8*addr[1:0]+:8] or half mem_rdata[16*addr[1]+:16]; sign-extend for 000/001, zero-extend for 100/101, word unchanged; register into resp_rdata; go to RESP.
REQ-029 RESP: resp_valid=1 for exactly one cycle, then IDLE; no backpressure on response.
REQ-030 Latency from accept edge: fault 1 cycle, store 2 cycles, load 3 cycles to resp_valid.
REQ-031 resp_rdata holds its value until the next load or fault response; stores leave it unchanged.
REQ-032 req_valid outside IDLE is ignored; request must be held until accepted.

Reset
REQ-033 rst forces IDLE immediately: req_ready=1; resp_valid, resp_fault, mem_we, mem_be all 0; resp_rdata, mem_addr, mem_wdata all 0.
REQ-034 rst mid-operation aborts the access: no mem_we pulse and no response; the in-flight request is dropped.

Structure
REQ-035 Shared package lsu_pkg holds the state enum and funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-036 Combinational sub-module load_formatter performs lane selection and extension (REQ-028).
REQ-037 All registers are in load_store_unit; no latches.

Verification
REQ-038 SW: addr=0x104, wdata=0xDEADBEEF -> ACCESS cycle: mem_addr=0x104, be=1111, we=1; resp_valid 2 cycles after accept, fault=0.
REQ-039 SB: addr=0x013, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x010.
REQ-040 LB/LBU: addr=0x102, mem_rdata=0x1280FF34 -> LB resp_rdata=0xFFFFFF80, LBU 0x00000080, resp_valid 3 cycles after accept.
REQ-041 LH: addr=0x102, mem_rdata=0x8001_0000 -> 0xFFFF8001; LW addr=0x101 -> resp_fault=1 after 1 cycle, mem_we/be never asserted.
REQ-042 Illegal: store with funct3=100 -> fault, no write; load funct3=011 -> fault, resp_rdata=0.
REQ-043 Reset mid-op: assert rst during READ_WAIT -> outputs per REQ-033 at once, no resp_valid; next request after release completes normally.
